// File: rtl/apb_spi_pkg.sv
// apb_spi_pkg: shared FSM state type, register addresses and CTRL/STATUS bit positions for apb_spi_regs
package apb_spi_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0002;
  localparam logic [15:0] ADDR_TXDATA = 16'h0004;
  localparam logic [15:0] ADDR_RXDATA = 16'h0006;
  localparam int CTRL_SPI_EN  = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_LSB = 8;
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_OVR    = 3;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: W-bit x DEPTH (power of two) FIFO; ports clk, rst, push/din, pop/dout (0 when empty), full, empty
module sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, do_push};
      rp <= rp + {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/apb_spi_regs.sv
// apb_spi_regs: APB register bank for SPI (pclk/rst, APB psel..pslverr, tx_data/valid/ready stream, rx_data/valid strobe, spi_en/clk_div/irq); APB_SPI_PSLVERR_EN enables pslverr
module apb_spi_regs
  import apb_spi_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int TX_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [15:0] paddr,
  input  logic [15:0] pwdata,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        spi_en,
  output logic [7:0]  clk_div,
  output logic        irq
);
  state_t state;
  logic [3:0] cnt;
  logic irq_en, rx_full, rx_overrun, tx_full, tx_empty;
  logic [15:0] rx_hold, rdata;
  logic commit, wr, rd, hit_ctrl, hit_st, hit_tx, hit_rx;
  assign hit_ctrl = paddr == ADDR_CTRL;
  assign hit_st = paddr == ADDR_STATUS;
  assign hit_tx = paddr == ADDR_TXDATA;
  assign hit_rx = paddr == ADDR_RXDATA;
  assign commit = psel & penable & pready;
  assign wr = commit & pwrite;
  assign rd = commit & ~pwrite;
  assign tx_valid = ~tx_empty;
  always_comb begin
    rdata = hit_ctrl ? {clk_div, 6'b0, irq_en, spi_en} :
            hit_st   ? {12'b0, rx_overrun, rx_full, tx_empty, tx_full} :
            hit_rx   ? rx_hold : '0;
  end
  assign prdata = (pready & ~pwrite) ? rdata : '0;
`ifdef APB_SPI_PSLVERR_EN
  logic err;
  assign err = ~(hit_ctrl | hit_st | hit_tx | hit_rx) | (pwrite & hit_rx) |
               (~pwrite & hit_tx) | (pwrite & hit_tx & tx_full);
  assign pslverr = pready & err;
`else
  assign pslverr = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pready <= 1'b0;
    end else if (state == IDLE) begin
      if (psel & ~penable) begin
        state <= ACCESS;
        cnt <= 4'(WAIT_STATES);
        pready <= WAIT_STATES == 0;
      end
    end else if (pready) begin
      state <= IDLE;
      pready <= 1'b0;
    end else begin
      cnt <= cnt - 4'd1;
      pready <= cnt == 4'd1;
    end
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      spi_en <= 1'b0;
      irq_en <= 1'b0;
      clk_div <= '0;
      rx_hold <= '0;
      rx_full <= 1'b0;
      rx_overrun <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr & hit_ctrl) begin
        spi_en <= pwdata[CTRL_SPI_EN];
        irq_en <= pwdata[CTRL_IRQ_EN];
        clk_div <= pwdata[CTRL_DIV_LSB +: 8];
      end
      if (rx_valid) rx_hold <= rx_data;
      rx_full <= rx_valid | (rx_full & ~(rd & hit_rx));
      rx_overrun <= (rx_valid & rx_full & ~(rd & hit_rx)) |
                    (rx_overrun & ~(wr & hit_st & pwdata[ST_RX_OVR]));
      irq <= irq_en & (rx_full | rx_overrun);
    end
  end
  sync_fifo #(.W(16), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk  (pclk),
    .rst  (rst),
    .push (wr & hit_tx),
    .pop  (tx_ready),
    .din  (pwdata),
    .dout (tx_data),
    .full (tx_full),
    .empty(tx_empty)
  );
endmodule

// File: tb/tb_apb_spi_regs.sv
// tb_apb_spi_regs: directed self-checking bench for apb_spi_regs with WAIT_STATES=3, TX_DEPTH=4
module tb_apb_spi_regs;
`ifdef APB_SPI_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic pclk = 0, rst = 1;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [15:0] paddr = 0, pwdata = 0, prdata, tx_data, rx_data = 0;
  logic pready, pslverr, tx_valid, tx_ready = 0, rx_valid = 0, spi_en, irq;
  logic [7:0] clk_div;
  logic [15:0] rd;
  logic se;
  int waits, checks = 0, errors = 0;
  apb_spi_regs #(.WAIT_STATES(3), .TX_DEPTH(4)) dut (
    .pclk(pclk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .spi_en(spi_en), .clk_div(clk_div), .irq(irq)
  );
  always #5 pclk = ~pclk;
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic apb(input logic w, input logic [15:0] a, input logic [15:0] d, input bit keep,
                     input bit inj, input logic [15:0] inj_d);
    psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    tick();
    penable = 1;
    waits = 1;
    while (!pready && waits < 40) begin
      tick();
      waits++;
    end
    if (!pready) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr %h got pready %b want 1", a, pready);
    end
    rd = prdata;
    se = pslverr;
    if (inj) begin
      rx_valid = 1; rx_data = inj_d;
    end
    tick();
    rx_valid = 0;
    if (!keep) begin
      psel = 0; penable = 0;
      tick();
    end
  endtask
  task automatic rx_pulse(input logic [15:0] d);
    rx_valid = 1; rx_data = d;
    tick();
    rx_valid = 0;
    tick();
  endtask
  task automatic test_reset();
    repeat (3) tick();
    checks++; if ({prdata, pready, pslverr, tx_valid, tx_data, spi_en, clk_div, irq} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h/%b/%b/%b/%h/%b/%h/%b want all 0",
                          prdata, pready, pslverr, tx_valid, tx_data, spi_en, clk_div, irq); end
    rst = 0;
    tick();
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL status_reset got %h want 0002", rd); end
    checks++; if (se !== 1'b0) begin errors++; $display("FAIL status_reset_err got %b want 0", se); end
    checks++; if (waits !== 4) begin errors++; $display("FAIL wait_states got %0d want 4", waits); end
    apb(0, 16'h0000, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL ctrl_reset got %h want 0000", rd); end
  endtask
  task automatic test_ctrl();
    apb(1, 16'h0000, 16'h1203, 0, 0, 0);
    checks++; if (waits !== 4) begin errors++; $display("FAIL ctrl_wr_waits got %0d want 4", waits); end
    checks++; if (spi_en !== 1'b1) begin errors++; $display("FAIL spi_en got %b want 1", spi_en); end
    checks++; if (clk_div !== 8'h12) begin errors++; $display("FAIL clk_div got %h want 12", clk_div); end
    apb(0, 16'h0000, 0, 0, 0, 0);
    checks++; if (rd !== 16'h1203) begin errors++; $display("FAIL ctrl_readback got %h want 1203", rd); end
  endtask
  task automatic test_tx_fifo();
    tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      apb(1, 16'h0004, 16'hA000 + 16'(i), 0, 0, 0);
      checks++; if (se !== (i == 4 ? ERR_EN : 1'b0)) begin
        errors++; $display("FAIL tx_push%0d_err got %b want %b", i, se, i == 4 ? ERR_EN : 1'b0); end
    end
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0001) begin errors++; $display("FAIL status_txfull got %h want 0001", rd); end
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (!tx_valid || tx_data !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL tx_drain%0d got %b/%h want 1/%h", i, tx_valid, tx_data, 16'hA000 + 16'(i)); end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty_after_drain got %b want 0", tx_valid); end
    tx_ready = 0;
  endtask
  task automatic test_rx();
    rx_pulse(16'h55AA);
    rx_pulse(16'h1234);
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h000E) begin errors++; $display("FAIL status_overrun got %h want 000e", rd); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    apb(0, 16'h0006, 0, 0, 0, 0);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL rxdata got %h want 1234", rd); end
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h000A) begin errors++; $display("FAIL status_after_pop got %h want 000a", rd); end
    apb(1, 16'h0002, 16'h0008, 0, 0, 0);
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL status_w1c got %h want 0002", rd); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
  endtask
  task automatic test_rx_same_cycle();
    rx_pulse(16'h1111);
    apb(0, 16'h0006, 0, 0, 1, 16'hBEEF);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL rx_same_old got %h want 1111", rd); end
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0006) begin errors++; $display("FAIL rx_same_status got %h want 0006", rd); end
    apb(0, 16'h0006, 0, 0, 0, 0);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rx_same_new got %h want beef", rd); end
  endtask
  task automatic test_errors();
    apb(1, 16'h0006, 16'hDEAD, 0, 0, 0);
    checks++; if (se !== ERR_EN) begin errors++; $display("FAIL wr_rxdata_err got %b want %b", se, ERR_EN); end
    apb(0, 16'h0006, 0, 0, 0, 0);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_rxdata_noeffect got %h want beef", rd); end
    apb(0, 16'h0004, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0000 || se !== ERR_EN) begin
      errors++; $display("FAIL rd_txdata got %h/%b want 0000/%b", rd, se, ERR_EN); end
  endtask
  task automatic test_back_to_back();
    apb(0, 16'h0010, 0, 1, 0, 0);
    checks++; if (rd !== 16'h0000 || se !== ERR_EN) begin
      errors++; $display("FAIL unmapped got %h/%b want 0000/%b", rd, se, ERR_EN); end
    apb(1, 16'h0000, 16'h3401, 0, 0, 0);
    checks++; if (waits !== 4) begin errors++; $display("FAIL b2b_waits got %0d want 4", waits); end
    checks++; if (spi_en !== 1'b1 || clk_div !== 8'h34) begin
      errors++; $display("FAIL b2b_ctrl got %b/%h want 1/34", spi_en, clk_div); end
  endtask
  task automatic test_reset_mid();
    apb(1, 16'h0004, 16'h7777, 0, 0, 0);
    rx_pulse(16'h4242);
    psel = 1; penable = 0; pwrite = 0; paddr = 16'h0000;
    tick();
    penable = 1;
    repeat (2) tick();
    rst = 1;
    tick();
    checks++; if (pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready got %b want 0", pready); end
    checks++; if (tx_valid !== 1'b0 || spi_en !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got %b/%b want 0/0", tx_valid, spi_en); end
    psel = 0; penable = 0; rst = 0;
    tick();
    apb(0, 16'h0002, 0, 0, 0, 0);
    checks++; if (rd !== 16'h0002) begin errors++; $display("FAIL rst_mid_status got %h want 0002", rd); end
  endtask
  initial begin
    test_reset();
    test_ctrl();
    test_tx_fifo();
    test_rx();
    test_rx_same_cycle();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
